// File: rtl/sseg_scan_decoder.sv
// Receive side of a 4-digit multiplexed 7-segment bus: filters the sampled {an,sseg},
// captures each digit once per stable dwell and reassembles a 16-bit hex value per scan frame.
module sseg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  an,
  input  logic [6:0]  sseg,
  output logic [15:0] value,
  output logic [3:0]  bad,
  output logic        frame_valid,
  output logic        seq_err,
  output logic        locked
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {SYNC, EXP1, EXP2, EXP3} state_t;

  state_t          state, next;
  logic [10:0]     samp, prev;
  logic [SW-1:0]   stab_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            pos_ok, cap, glyph_bad, counting, tmo_hit;
  logic [1:0]      pos, exp_pos;
  logic [3:0]      nib;
  logic            store, err_n, commit_n, commit_q;
  logic [15:0]     shadow;
  logic [3:0]      shadow_bad;

  always_comb begin
    pos_ok = 1'b1;
    pos    = 2'd0;
    case (samp[10:7])
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: pos_ok = 1'b0;
    endcase
  end

  always_comb begin
    glyph_bad = 1'b0;
    nib       = 4'h0;
    case (samp[6:0])
      7'b1000000: nib = 4'h0;
      7'b1111001: nib = 4'h1;
      7'b0100100: nib = 4'h2;
      7'b0110000: nib = 4'h3;
      7'b0011001: nib = 4'h4;
      7'b0010010: nib = 4'h5;
      7'b0000010: nib = 4'h6;
      7'b1111000: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0010000: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b0000011: nib = 4'hB;
      7'b1000110: nib = 4'hC;
      7'b0100001: nib = 4'hD;
      7'b0000110: nib = 4'hE;
      7'b0001110: nib = 4'hF;
      default:    glyph_bad = 1'b1;
    endcase
  end

  // Capture fires only on the step into STABLE_CYCLES; saturation keeps one capture per dwell.
  assign cap = pos_ok && (samp == prev) && (stab_cnt == SW'(STABLE_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      samp     <= '0;
      prev     <= '0;
      stab_cnt <= '0;
    end else begin
      samp <= {an, sseg};
      prev <= samp;
      if (!pos_ok)
        stab_cnt <= '0;
      else if (samp != prev)
        stab_cnt <= SW'(1);
      else if (stab_cnt != SW'(STABLE_CYCLES))
        stab_cnt <= stab_cnt + 1'b1;
    end
  end

  assign counting = (state != SYNC) || locked;
  assign tmo_hit  = counting && !cap && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RESET || cap || !counting)
      tmo_cnt <= '0;
    else if (tmo_cnt != TW'(TIMEOUT_CYCLES))
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= SYNC;
    else       state <= next;
  end

  always_comb begin
    case (state)
      EXP1:    exp_pos = 2'd1;
      EXP2:    exp_pos = 2'd2;
      EXP3:    exp_pos = 2'd3;
      default: exp_pos = 2'd0;
    endcase
  end

  always_comb begin
    next = state;
    if (tmo_hit)
      next = SYNC;
    else if (cap) begin
      if (state == SYNC)
        next = (pos == 2'd0) ? EXP1 : SYNC;
      else if (pos == exp_pos)
        case (state)
          EXP1:    next = EXP2;
          EXP2:    next = EXP3;
          default: next = SYNC;
        endcase
      else if (pos == 2'd0)
        next = EXP1;
      else
        next = SYNC;
    end
  end

  always_comb begin
    store    = 1'b0;
    err_n    = 1'b0;
    commit_n = 1'b0;
    if (cap && !tmo_hit) begin
      if (state == SYNC)
        store = (pos == 2'd0);
      else if (pos == exp_pos) begin
        store    = 1'b1;
        commit_n = (state == EXP3);
      end else begin
        err_n = 1'b1;
        store = (pos == 2'd0);
      end
    end
  end

  // Frame commit lags the pos3 capture by one cycle so value/bad/frame_valid update together.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      shadow      <= '0;
      shadow_bad  <= '0;
      value       <= '0;
      bad         <= '0;
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;
      locked      <= 1'b0;
      commit_q    <= 1'b0;
    end else begin
      seq_err     <= err_n;
      commit_q    <= commit_n;
      frame_valid <= commit_q;
      if (store) begin
        shadow[{pos, 2'b00} +: 4] <= nib;
        shadow_bad[pos]           <= glyph_bad;
      end
      if (commit_q) begin
        value  <= shadow;
        bad    <= shadow_bad;
        locked <= 1'b1;
      end else if (tmo_hit)
        locked <= 1'b0;
    end
  end

endmodule
